// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_W          = 32;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // Memory depth in words, one bit wider than the header so 2**32 still fits.
    function automatic logic [HDR_W:0] depth_words(input int addr_w);
        return (HDR_W+1)'(1) << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input, instruction-memory write port and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_done, load_error
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_done, load_error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs four stream bytes big-endian into a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clr_i,
    input  wire logic             accept_i,
    input  wire logic [7:0]       byte_i,
    output logic                  word_ready_o,
    output logic [HDR_W-1:0]      word_o
);

    // Only the first three bytes are staged; the fourth completes the word in-flight.
    logic [HDR_W-9:0] shift_q;
    logic [1:0]       cnt_q;

    assign word_ready_o = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {shift_q, byte_i};

    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (accept_i) begin
            shift_q <= {shift_q[HDR_W-17:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed byte stream into instruction memory and
//               holds the CPU until done. IMEM_LOADER_CHECKSUM_EN adds a trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic       clock,
    input  wire logic       reset,
    imem_loader_if.master   bus
);

    localparam logic [HDR_W:0] c_depth = depth_words(ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e c_after_data = CHK;
`else
    localparam state_e c_after_data = DONE;
`endif

    state_e            state_q;
    logic              byte_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       imem_wdata_q;
    logic [HDR_W-1:0]  n_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [HDR_W-1:0]  sum_q;
`endif

    logic              w_accept;
    logic              w_clr;
    logic              w_word_ready;
    logic [HDR_W-1:0]  w_word;
    logic              w_last;

    assign w_accept = bus.byte_valid && byte_ready_q;
    assign w_clr    = (state_q == WRITE) || (state_q == DONE) || (state_q == ERR);
    assign w_last   = (HDR_W'(idx_q) == n_q - 32'd1);

    byte_word_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .clr_i        (w_clr),
        .accept_i     (w_accept),
        .byte_i       (bus.byte_data),
        .word_ready_o (w_word_ready),
        .word_o       (w_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HDR;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                HDR: begin
                    byte_ready_q <= 1'b1;
                    if (w_word_ready) begin
                        n_q <= w_word;
                        if (w_word == '0) begin
                            // Empty image goes straight to the trailer or to completion.
                            state_q      <= c_after_data;
                            byte_ready_q <= (c_after_data == CHK);
                            load_done_q  <= (c_after_data == DONE);
                            cpu_hold_q   <= (c_after_data != DONE);
                        end else if ({1'b0, w_word} > c_depth) begin
                            state_q      <= ERR;
                            byte_ready_q <= 1'b0;
                            load_error_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_word_ready) begin
                        state_q      <= WRITE;
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= idx_q;
                        imem_wdata_q <= w_word;
                    end
                end
                WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_q <= sum_q + imem_wdata_q;
`endif
                    if (w_last) begin
                        state_q      <= c_after_data;
                        byte_ready_q <= (c_after_data == CHK);
                        load_done_q  <= (c_after_data == DONE);
                        cpu_hold_q   <= (c_after_data != DONE);
                    end else begin
                        state_q      <= DATA;
                        idx_q        <= idx_q + 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_word_ready) begin
                        byte_ready_q <= 1'b0;
                        if (w_word == sum_q) begin
                            state_q     <= DONE;
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            state_q      <= ERR;
                            load_error_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE: byte_ready_q <= 1'b0;
                ERR:  byte_ready_q <= 1'b0;
                default: begin
                    // Unreachable encodings fail safe with the CPU still held.
                    state_q      <= ERR;
                    byte_ready_q <= 1'b0;
                    load_error_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed bench for imem_loader with a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stream-level model: counts accepted bytes and derives what the loader must show.
    bit          m_rdy, m_done, m_err, m_done_next;
    int          m_cnt;
    longint      m_n;
    logic [31:0] m_acc, m_sum;

    always @(negedge clock) begin : mon
        bit          hs, ewe, erdy;
        int          k, eaddr;
        logic [31:0] edata;
        if (reset) begin
            chk("rst_ready", bus.byte_ready, 0);
            chk("rst_we",    bus.imem_we,    0);
            chk("rst_hold",  bus.cpu_hold,   1);
            chk("rst_done",  bus.load_done,  0);
            chk("rst_err",   bus.load_error, 0);
            m_rdy = 0; m_done = 0; m_err = 0; m_done_next = 0;
            m_cnt = 0; m_n = 0; m_acc = 0; m_sum = 0;
        end else begin
            ewe = 0; eaddr = 0; edata = 0;
            if (m_done_next) begin
                m_done = 1; m_done_next = 0;
            end
            hs = bus.byte_valid && m_rdy;
            if (hs) begin
                m_acc = {m_acc[23:0], bus.byte_data};
                m_cnt++;
                if (m_cnt % 4 == 0) begin
                    k = m_cnt / 4;
                    if (k == 1) begin
                        m_n = longint'(m_acc);
                        if (m_n == 0) m_done = !CK;
                        else if (m_n > DEPTH) m_err = 1;
                    end else if (longint'(k - 2) < m_n) begin
                        ewe = 1; eaddr = k - 2; edata = m_acc;
                        m_sum = m_sum + m_acc;
                        if (longint'(k - 2) == m_n - 1 && !CK) m_done_next = 1;
                    end else begin
                        if (m_acc == m_sum) m_done = 1;
                        else m_err = 1;
                    end
                end
            end
            erdy = !(m_done || m_err || ewe);
            chk("ready", bus.byte_ready, erdy);
            chk("we",    bus.imem_we,    ewe);
            if (ewe) begin
                chk("addr",  bus.imem_addr,  eaddr);
                chk("wdata", bus.imem_wdata, edata);
            end
            chk("done", bus.load_done,  m_done);
            chk("err",  bus.load_error, m_err);
            chk("hold", bus.cpu_hold,   !m_done);
            m_rdy = erdy;
        end
        if (bus.imem_we) wlog.push_back('{addr: int'(bus.imem_addr), data: bus.imem_wdata});
    end

    task automatic do_reset();
        @(negedge clock); #1;
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clock);
        chk("rstlit_ready", bus.byte_ready, 0);
        chk("rstlit_we",    bus.imem_we,    0);
        chk("rstlit_addr",  bus.imem_addr,  0);
        chk("rstlit_wdata", bus.imem_wdata, 0);
        chk("rstlit_hold",  bus.cpu_hold,   1);
        chk("rstlit_done",  bus.load_done,  0);
        chk("rstlit_err",   bus.load_error, 0);
        #1;
        reset = 1'b0;
        wlog.delete();
    endtask

    // Called at negedge+1; returns at negedge+1 after the handshake edge, valid left high.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) begin @(negedge clock); #1; end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t = 0;
        while (!bus.byte_ready && t < 200) begin
            @(negedge clock); #1;
            t++;
        end
        if (!bus.byte_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
        end
        @(negedge clock); #1;
    endtask

    task automatic idle(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) begin @(negedge clock); #1; end
    endtask

    task automatic stream1(input int gmax, input int nbytes, input logic [7:0] last_trailer);
        logic [7:0] s [16];
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
              8'h00, 8'h22, 8'h18, 8'h20, 8'h20, 8'h23, 8'h18, 8'h25};
        s[15] = last_trailer;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 12 || CK) send(s[i], (gmax > 0) ? $urandom_range(0, gmax) : 0);
        end
    endtask

    task automatic check_t1(input string tag);
        chk({tag, "_nwr"}, wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk({tag, "_a0"}, wlog[0].addr, 0);
            chk({tag, "_d0"}, wlog[0].data, 32'h2001_0005);
            chk({tag, "_a1"}, wlog[1].addr, 1);
            chk({tag, "_d1"}, wlog[1].data, 32'h0022_1820);
        end
        chk({tag, "_done"}, bus.load_done, 1);
        chk({tag, "_hold"}, bus.cpu_hold,  0);
    endtask

    initial begin
        logic [31:0] w, sum;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // 1: two-word image, valid held high
        do_reset();
        stream1(0, 16, 8'h25);
        idle(3);
        check_t1("t1");

        // 2: empty image, later bytes ignored
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h00, 0);
        if (CK) for (int i = 0; i < 4; i++) send(8'h00, 0);
        bus.byte_data = 8'h5A;
        repeat (3) begin @(negedge clock); #1; end
        idle(1);
        chk("t2_nwr",  wlog.size(), 0);
        chk("t2_done", bus.load_done, 1);

        // 3a: 257 words overflows a 256-word memory
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0); send(8'h01, 0);
        idle(2);
        chk("t3_err",   bus.load_error, 1);
        chk("t3_ready", bus.byte_ready, 0);
        chk("t3_nwr",   wlog.size(), 0);

        // 3b: exactly 256 words fills the memory
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
        sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = {i[7:0], ~i[7:0], 8'hA5, i[7:0]};
            sum = sum + w;
            for (int b = 3; b >= 0; b--) send(w[b*8 +: 8], 0);
        end
        if (CK) for (int b = 3; b >= 0; b--) send(sum[b*8 +: 8], 0);
        idle(3);
        chk("t3_nwr256", wlog.size(), DEPTH);
        if (wlog.size() == DEPTH) begin
            chk("t3_d0",    wlog[0].data, 32'h00FF_A500);
            chk("t3_alast", wlog[DEPTH-1].addr, 8'hFF);
            chk("t3_dlast", wlog[DEPTH-1].data, 32'hFF00_A5FF);
        end
        chk("t3_done", bus.load_done, 1);

        // 4: same image with random valid gaps
        do_reset();
        stream1(3, 16, 8'h25);
        idle(3);
        check_t1("t4");

        // 5: reset after six bytes, then a fresh full load
        do_reset();
        stream1(0, 6, 8'h25);
        do_reset();
        stream1(0, 16, 8'h25);
        idle(3);
        check_t1("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: bad trailer
        do_reset();
        stream1(0, 16, 8'h26);
        idle(3);
        chk("t6_err",  bus.load_error, 1);
        chk("t6_hold", bus.cpu_hold,   1);
        chk("t6_done", bus.load_done,  0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
